fft_band_flag_gen: RTL and testbench

//  Produces the acoustic fire flag consumed as fft_flag_in by the fire alert fuser.

---
 rtl/fft_band_flag_gen.sv | 191 +++++++++++++++++++
 tb/tb_fft_band_flag_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_band_flag_gen.sv
// Streaming FFT band-energy detector: sums a fixed bin band per frame, compares it to a
// threshold, and raises a stretched level flag after enough consecutive hit frames.
module fft_band_flag_gen #(
  parameter int unsigned N_BINS      = 512,
  parameter int unsigned BIN_IDX_W   = 9,
  parameter int unsigned MAG_W       = 16,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned BAND_LO     = 40,
  parameter int unsigned BAND_HI     = 80,
  parameter int unsigned HIT_FRAMES  = 3,
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [ACC_W-1:0] threshold,
  input  logic             bin_valid,
  input  logic             bin_last,
  input  logic [MAG_W-1:0] bin_mag,
  output logic             fft_flag_out,
  output logic [ACC_W-1:0] band_energy,
  output logic             energy_valid,
  output logic             frame_err
);

  localparam int unsigned CNT_W  = $clog2(HIT_FRAMES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [BIN_IDX_W-1:0] LAST_IDX  = BIN_IDX_W'(N_BINS - 1);
  localparam logic [BIN_IDX_W-1:0] LO_IDX    = BIN_IDX_W'(BAND_LO);
  localparam logic [BIN_IDX_W-1:0] HI_IDX    = BIN_IDX_W'(BAND_HI);
  localparam logic [CNT_W-1:0]     CNT_FULL  = CNT_W'(HIT_FRAMES);
  localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {RX_SYNC, RX_ACCUM, RX_DISCARD} rx_state_e;
  typedef enum logic       {FLAG_QUIET, FLAG_ALERT}        flag_state_e;

  rx_state_e             rx_state_q, rx_state_d;
  logic [BIN_IDX_W-1:0]  idx_q, idx_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [ACC_W-1:0]      band_energy_q, band_energy_d;
  logic                  energy_valid_q, energy_valid_d;
  logic                  frame_err_q, frame_err_d;
  flag_state_e           flag_state_q, flag_state_d;
  logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;

  logic                  in_band;
  logic [ACC_W:0]        addend;
  logic [ACC_W:0]        sum_ext;
  logic [ACC_W-1:0]      sum_sat;
  logic                  good_frame;
  logic                  frame_hit;
  logic                  frame_bad;

  // Carry out of the widened add means the band sum overflowed; clamp instead of wrapping.
  always_comb begin
    in_band = (idx_q >= LO_IDX) && (idx_q <= HI_IDX);
    addend  = in_band ? {{(ACC_W + 1 - MAG_W){1'b0}}, bin_mag} : '0;
    sum_ext = {1'b0, acc_q} + addend;
    sum_sat = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
  end

  // NOTE: every signal written here gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    rx_state_d     = rx_state_q;
    idx_d          = idx_q;
    acc_d          = acc_q;
    band_energy_d  = band_energy_q;
    energy_valid_d = 1'b0;
    frame_err_d    = 1'b0;
    good_frame     = 1'b0;
    frame_hit      = 1'b0;
    frame_bad      = 1'b0;

    if (!enable) begin
      rx_state_d = RX_SYNC;
      idx_d      = '0;
      acc_d      = '0;
    end else if (bin_valid) begin
      case (rx_state_q)
        RX_SYNC, RX_DISCARD: begin
          if (bin_last) begin
            rx_state_d = RX_ACCUM;
            idx_d      = '0;
            acc_d      = '0;
          end
        end
        RX_ACCUM: begin
          if (bin_last) begin
            idx_d = '0;
            acc_d = '0;
            if (idx_q == LAST_IDX) begin
              good_frame     = 1'b1;
              frame_hit      = (sum_sat >= threshold);
              band_energy_d  = sum_sat;
              energy_valid_d = 1'b1;
            end else begin
              frame_bad   = 1'b1;
              frame_err_d = 1'b1;
            end
          end else if (idx_q == LAST_IDX) begin
            // Frame overran without a last marker: drop everything up to the next one.
            frame_bad   = 1'b1;
            frame_err_d = 1'b1;
            rx_state_d  = RX_DISCARD;
            idx_d       = '0;
            acc_d       = '0;
          end else begin
            idx_d = idx_q + BIN_IDX_W'(1);
            acc_d = sum_sat;
          end
        end
        default: rx_state_d = RX_SYNC;
      endcase
    end
  end

  always_comb begin
    flag_state_d = flag_state_q;
    hit_cnt_d    = hit_cnt_q;
    hold_d       = hold_q;

    if (!enable) begin
      flag_state_d = FLAG_QUIET;
      hit_cnt_d    = '0;
      hold_d       = '0;
    end else begin
      case (flag_state_q)
        FLAG_QUIET: begin
          if (frame_bad || (good_frame && !frame_hit)) begin
            hit_cnt_d = '0;
          end else if (good_frame && frame_hit) begin
            if (hit_cnt_q >= CNT_FULL - CNT_W'(1)) begin
              hit_cnt_d    = CNT_FULL;
              flag_state_d = FLAG_ALERT;
              hold_d       = HOLD_LOAD;
            end else begin
              hit_cnt_d = hit_cnt_q + CNT_W'(1);
            end
          end
        end
        FLAG_ALERT: begin
          // Only a fresh hit extends the hold; misses and errors let it run down untouched.
          if (good_frame && frame_hit) begin
            hold_d = HOLD_LOAD;
          end else if (hold_q <= HOLD_W'(1)) begin
            flag_state_d = FLAG_QUIET;
            hold_d       = '0;
            hit_cnt_d    = '0;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        default: flag_state_d = FLAG_QUIET;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q     <= RX_SYNC;
      idx_q          <= '0;
      acc_q          <= '0;
      band_energy_q  <= '0;
      energy_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      flag_state_q   <= FLAG_QUIET;
      hit_cnt_q      <= '0;
      hold_q         <= '0;
    end else begin
      rx_state_q     <= rx_state_d;
      idx_q          <= idx_d;
      acc_q          <= acc_d;
      band_energy_q  <= band_energy_d;
      energy_valid_q <= energy_valid_d;
      frame_err_q    <= frame_err_d;
      flag_state_q   <= flag_state_d;
      hit_cnt_q      <= hit_cnt_d;
      hold_q         <= hold_d;
    end
  end

  assign fft_flag_out = (flag_state_q == FLAG_ALERT);
  assign band_energy  = band_energy_q;
  assign energy_valid = energy_valid_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_fft_band_flag_gen.sv
// Directed bench for fft_band_flag_gen with 16-bin frames, band 4..7, 3 hits, 20-cycle hold.
module tb_fft_band_flag_gen;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [16:0] threshold;
  logic        bin_valid;
  logic        bin_last;
  logic [15:0] bin_mag;
  logic        fft_flag_out;
  logic [16:0] band_energy;
  logic        energy_valid;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;
  int n_high;

  fft_band_flag_gen #(
    .N_BINS     (16),
    .BIN_IDX_W  (4),
    .MAG_W      (16),
    .ACC_W      (17),
    .BAND_LO    (4),
    .BAND_HI    (7),
    .HIT_FRAMES (3),
    .HOLD_CYCLES(20)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .threshold   (threshold),
    .bin_valid   (bin_valid),
    .bin_last    (bin_last),
    .bin_mag     (bin_mag),
    .fft_flag_out(fft_flag_out),
    .band_energy (band_energy),
    .energy_valid(energy_valid),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One beat; returns #1 after the capturing edge with the bus idle again.
  task automatic beat(input logic [15:0] mag, input logic last);
    bin_valid = 1'b1;
    bin_mag   = mag;
    bin_last  = last;
    @(posedge clk);
    #1;
    bin_valid = 1'b0;
    bin_last  = 1'b0;
    bin_mag   = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full 16-bin frame: band bins 4..7 get b4..b7, out-of-band bins carry 100.
  task automatic frame(input logic [15:0] b4, input logic [15:0] b5,
                       input logic [15:0] b6, input logic [15:0] b7);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] m;
      case (i)
        4:       m = b4;
        5:       m = b5;
        6:       m = b6;
        7:       m = b7;
        default: m = 16'd100;
      endcase
      beat(m, i == 15);
    end
  endtask

  // Beats with band-pattern data; bin_last only on the final beat if requested.
  task automatic partial(input int n, input logic last_at_end);
    for (int i = 0; i < n; i++) begin
      beat((i >= 4 && i <= 7) ? 16'd10 : 16'd100, last_at_end && (i == n - 1));
    end
  endtask

  task automatic measure_high(output int n);
    n = 0;
    while (fft_flag_out === 1'b1 && n < 200) begin
      n++;
      idle(1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    threshold = 17'd40;
    bin_valid = 1'b0;
    bin_last  = 1'b0;
    bin_mag   = '0;
    idle(3);
    check("reset_flag",   32'(fft_flag_out), 32'd0);
    check("reset_energy", 32'(band_energy),  32'd0);
    check("reset_ev",     32'(energy_valid), 32'd0);
    check("reset_err",    32'(frame_err),    32'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    idle(1);

    // 1: sync frame, then three hit frames raise the flag for 20 cycles.
    frame(10, 10, 10, 10);
    check("sync_no_ev", 32'(energy_valid), 32'd0);
    frame(10, 10, 10, 10);
    check("t1_f1_ev",     32'(energy_valid), 32'd1);
    check("t1_f1_energy", 32'(band_energy),  32'd40);
    check("t1_f1_err",    32'(frame_err),    32'd0);
    check("t1_f1_flag",   32'(fft_flag_out), 32'd0);
    idle(1);
    check("t1_ev_pulse", 32'(energy_valid), 32'd0);
    frame(10, 10, 10, 10);
    check("t1_f2_flag", 32'(fft_flag_out), 32'd0);
    frame(10, 10, 10, 10);
    check("t1_f3_flag", 32'(fft_flag_out), 32'd1);
    check("t1_f3_ev",   32'(energy_valid), 32'd1);
    measure_high(n_high);
    check("t1_hold_len", 32'(n_high), 32'd20);

    // 2: a miss resets the run of hits.
    frame(10, 10, 10, 10);
    frame(10, 10, 10, 10);
    frame(10, 10, 10, 9);
    check("t2_miss_energy", 32'(band_energy),  32'd39);
    check("t2_miss_flag",   32'(fft_flag_out), 32'd0);
    frame(10, 10, 10, 10);
    frame(10, 10, 10, 10);
    check("t2_two_hits_flag", 32'(fft_flag_out), 32'd0);
    frame(10, 10, 10, 10);
    check("t2_third_hit_flag", 32'(fft_flag_out), 32'd1);

    // 5: hit during hold reloads it; a following miss neither extends nor shortens it.
    frame(10, 10, 10, 10);
    check("t5_reload_flag", 32'(fft_flag_out), 32'd1);
    frame(10, 10, 10, 9);
    check("t5_miss_flag",   32'(fft_flag_out), 32'd1);
    check("t5_miss_energy", 32'(band_energy),  32'd39);
    measure_high(n_high);
    check("t5_hold_remaining", 32'(n_high), 32'd4);

    // 3: saturation of the band sum; threshold equal to the saturated value still hits.
    threshold = 17'h1FFFF;
    frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    check("t3_sat_energy", 32'(band_energy),  32'h1FFFF);
    check("t3_sat_ev",     32'(energy_valid), 32'd1);
    threshold = 17'd40;

    // 4: early bin_last clears the hit count.
    frame(10, 10, 10, 10);
    partial(10, 1'b1);
    check("t4_early_err", 32'(frame_err),    32'd1);
    check("t4_early_ev",  32'(energy_valid), 32'd0);
    frame(10, 10, 10, 10);
    frame(10, 10, 10, 10);
    check("t4_cnt_cleared_flag", 32'(fft_flag_out), 32'd0);
    // Overrun without bin_last, then a discarded frame.
    partial(16, 1'b0);
    check("t4_overrun_err", 32'(frame_err), 32'd1);
    partial(16, 1'b1);
    check("t4_discard_ev",  32'(energy_valid), 32'd0);
    check("t4_discard_err", 32'(frame_err),    32'd0);
    frame(10, 10, 10, 10);
    frame(10, 10, 10, 10);
    check("t4_after_discard_flag", 32'(fft_flag_out), 32'd0);
    frame(10, 10, 10, 10);
    check("t4_third_hit_flag", 32'(fft_flag_out), 32'd1);

    // 6: enable drop mid-frame during ALERT.
    partial(5, 1'b0);
    enable = 1'b0;
    beat(16'd10, 1'b0);
    check("t6_dis_flag",   32'(fft_flag_out), 32'd0);
    check("t6_dis_ev",     32'(energy_valid), 32'd0);
    check("t6_dis_energy", 32'(band_energy),  32'd40);
    partial(3, 1'b0);
    enable = 1'b1;
    partial(6, 1'b1);
    check("t6_partial_ev",  32'(energy_valid), 32'd0);
    check("t6_partial_err", 32'(frame_err),    32'd0);
    frame(10, 10, 10, 10);
    check("t6_resync_ev",     32'(energy_valid), 32'd1);
    check("t6_resync_energy", 32'(band_energy),  32'd40);
    frame(10, 10, 10, 10);
    check("t6_cnt_restart_flag", 32'(fft_flag_out), 32'd0);
    frame(10, 10, 10, 10);
    check("t6_realert_flag", 32'(fft_flag_out), 32'd1);

    // Async reset mid-frame and mid-hold.
    partial(5, 1'b0);
    reset_n = 1'b0;
    #1;
    check("t6_rst_flag",   32'(fft_flag_out), 32'd0);
    check("t6_rst_energy", 32'(band_energy),  32'd0);
    #2;
    reset_n = 1'b1;
    partial(4, 1'b1);
    check("t6_rst_sync_ev",  32'(energy_valid), 32'd0);
    check("t6_rst_sync_err", 32'(frame_err),    32'd0);
    frame(10, 10, 10, 10);
    check("t6_rst_resync_ev",     32'(energy_valid), 32'd1);
    check("t6_rst_resync_energy", 32'(band_energy),  32'd40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
